// File: rtl/iopmp_entry_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | iopmp_entry_sequencer_pkg: states, completion codes, entry offsets     |
// | and default register-bus types for the IOPMP entry sequencer. Rev 1.0  |
// +-----------------------------------------------------------------------+
package iopmp_entry_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIS   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_ADDRH = 3'd3,
    ST_CFG   = 3'd4,
    ST_RESP  = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_BUS_ERR = 2'd1,
    RSP_TIMEOUT = 2'd2,
    RSP_BAD_IDX = 2'd3
  } rsp_code_e;

  localparam logic [13:0] c_ENTRY_ADDR_OFF  = 14'd0;
  localparam logic [13:0] c_ENTRY_ADDRH_OFF = 14'd4;
  localparam logic [13:0] c_ENTRY_CFG_OFF   = 14'd8;
  localparam logic [13:0] c_ENTRY_STRIDE    = 14'd16;

  typedef struct packed {
    logic [13:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } iopmp_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } iopmp_reg_rsp_t;

endpackage
`default_nettype wire

// File: rtl/iopmp_entry_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | iopmp_entry_sequencer: programs one IOPMP entry (disable, addr, addrh, |
// | cfg) over the register bus per command and reports a completion code.  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module iopmp_entry_sequencer
  import iopmp_entry_sequencer_pkg::*;
#(
  parameter int unsigned NUMBER_ENTRIES = 32,
  parameter logic [13:0] ENTRY_BASE     = 14'h2000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter type         reg_req_t      = iopmp_reg_req_t,
  parameter type         reg_rsp_t      = iopmp_reg_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_idx_i,
  input  logic [63:0] cmd_addr_i,
  input  logic [31:0] cmd_cfg_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [1:0]  rsp_code_o,
  output reg_req_t    reg_req_o,
  input  reg_rsp_t    reg_rsp_i,
  output logic        busy_o
);

  localparam int unsigned        c_CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST   = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]         c_NUM_ENTRIES = 9'(NUMBER_ENTRIES);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  rsp_code_e           r_code;
  rsp_code_e           w_code_nxt;
  logic                w_code_load;
  logic [7:0]          r_idx;
  logic [63:0]         r_addr;
  logic [31:0]         r_cfg;
  logic [c_CNT_W-1:0]  r_wait;
  logic                w_accept;
  logic                w_bad_idx;
  logic                w_wr_active;
  logic [13:0]         w_entry;
  logic                w_unused;

  assign w_accept  = (r_state == ST_IDLE) && cmd_valid_i;
  assign w_bad_idx = ({1'b0, cmd_idx_i} >= c_NUM_ENTRIES);
  assign w_entry   = ENTRY_BASE + ({6'd0, r_idx} * c_ENTRY_STRIDE);
  assign rsp_code_o = r_code;
  assign w_unused  = ^{reg_rsp_i.rdata, r_addr[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_load = 1'b0;
    w_code_nxt  = RSP_OK;
    w_wr_active = 1'b0;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    reg_req_o   = '0;

    case (r_state)
      ST_IDLE: begin
        busy_o      = 1'b0;
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (w_bad_idx) begin
            w_state_nxt = ST_RESP;
            w_code_load = 1'b1;
            w_code_nxt  = RSP_BAD_IDX;
          end else begin
            w_state_nxt = ST_DIS;
          end
        end
      end
      // Entry is disabled first so it is never live with a half-written address.
      ST_DIS: begin
        w_wr_active     = 1'b1;
        reg_req_o.addr  = w_entry + c_ENTRY_CFG_OFF;
        reg_req_o.wdata = 32'd0;
        if (reg_rsp_i.ready) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        w_wr_active     = 1'b1;
        reg_req_o.addr  = w_entry + c_ENTRY_ADDR_OFF;
        reg_req_o.wdata = r_addr[33:2];
        if (reg_rsp_i.ready) w_state_nxt = ST_ADDRH;
      end
      ST_ADDRH: begin
        w_wr_active     = 1'b1;
        reg_req_o.addr  = w_entry + c_ENTRY_ADDRH_OFF;
        reg_req_o.wdata = {2'b00, r_addr[63:34]};
        if (reg_rsp_i.ready) w_state_nxt = ST_CFG;
      end
      ST_CFG: begin
        w_wr_active     = 1'b1;
        reg_req_o.addr  = w_entry + c_ENTRY_CFG_OFF;
        reg_req_o.wdata = r_cfg;
        if (reg_rsp_i.ready) begin
          w_state_nxt = ST_RESP;
          w_code_load = 1'b1;
          w_code_nxt  = RSP_OK;
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A completing write beats the timeout; a bus error aborts the rest.
    if (w_wr_active) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.write = 1'b1;
      reg_req_o.wstrb = 4'hF;
      if (reg_rsp_i.ready) begin
        if (reg_rsp_i.error) begin
          w_state_nxt = ST_RESP;
          w_code_load = 1'b1;
          w_code_nxt  = RSP_BUS_ERR;
        end
      end else if (r_wait == c_WAIT_LAST) begin
        w_state_nxt = ST_RESP;
        w_code_load = 1'b1;
        w_code_nxt  = RSP_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx  <= 8'd0;
      r_addr <= 64'd0;
      r_cfg  <= 32'd0;
      r_wait <= '0;
      r_code <= RSP_OK;
    end else begin
      if (w_accept) begin
        r_idx  <= cmd_idx_i;
        r_addr <= cmd_addr_i;
        r_cfg  <= cmd_cfg_i;
      end
      if (w_code_load) r_code <= w_code_nxt;
      if (w_state_nxt != r_state) begin
        r_wait <= '0;
      end else if (w_wr_active && !reg_rsp_i.ready) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iopmp_entry_sequencer.sv
`default_nettype none
// Directed bench for iopmp_entry_sequencer: cycle-exact write sequences,
// bad index, bus error, timeout boundary, back-pressure and mid-sequence reset.
module tb_iopmp_entry_sequencer;
  import iopmp_entry_sequencer_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           cmd_valid_i;
  logic           cmd_ready_o;
  logic [7:0]     cmd_idx_i;
  logic [63:0]    cmd_addr_i;
  logic [31:0]    cmd_cfg_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [1:0]     rsp_code_o;
  iopmp_reg_req_t reg_req_o;
  iopmp_reg_rsp_t reg_rsp_i;
  logic           busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cycles = 0;
  logic [13:0] log_addr[$];
  logic [31:0] log_data[$];

  always #5 clk_i = ~clk_i;

  iopmp_entry_sequencer #(
    .NUMBER_ENTRIES(32),
    .ENTRY_BASE    (14'h2000),
    .TIMEOUT_CYCLES(255),
    .reg_req_t     (iopmp_reg_req_t),
    .reg_rsp_t     (iopmp_reg_rsp_t)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_idx_i  (cmd_idx_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_cfg_i  (cmd_cfg_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_code_o (rsp_code_o),
    .reg_req_o  (reg_req_o),
    .reg_rsp_i  (reg_rsp_i),
    .busy_o     (busy_o)
  );

  // Inputs change 1 time unit after the rising edge; the bus is observed at the falling edge.
  always @(negedge clk_i) begin
    if (reg_req_o.valid) valid_cycles++;
    if (reg_req_o.valid && reg_rsp_i.ready) begin
      log_addr.push_back(reg_req_o.addr);
      log_data.push_back(reg_req_o.wdata);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cmd_valid_i = 1'b0; rsp_ready_i = 1'b0; reg_rsp_i = '0;
    cmd_idx_i = '0; cmd_addr_i = '0; cmd_cfg_i = '0;
    tick(); tick();
    n_checks++;
    if ({cmd_ready_o, rsp_valid_o, rsp_code_o, busy_o} !== 5'b10000) begin
      n_errors++; $display("FAIL reset_in: got %b required 10000", {cmd_ready_o, rsp_valid_o, rsp_code_o, busy_o});
    end
    rst_i = 1'b0;
    tick();
    n_checks++;
    if ({cmd_ready_o, rsp_valid_o, rsp_code_o, busy_o} !== 5'b10000) begin
      n_errors++; $display("FAIL reset_out: got %b required 10000", {cmd_ready_o, rsp_valid_o, rsp_code_o, busy_o});
    end
    n_checks++;
    if (reg_req_o !== '0) begin
      n_errors++; $display("FAIL reset_req: got %h required 0", reg_req_o);
    end
  endtask

  task automatic test_program();
    logic [7:0]  vi[2];
    logic [63:0] va[2];
    logic [31:0] vc[2];
    logic [13:0] ea[2][4];
    logic [31:0] ed[2][4];
    vi[0] = 8'd3;  va[0] = 64'h0000_0000_8000_1000; vc[0] = 32'h0000_0007;
    vi[1] = 8'd31; va[1] = 64'hFFFF_FFFF_0000_0004; vc[1] = 32'hA5A5_0F0F;
    ea[0] = '{14'h2038, 14'h2030, 14'h2034, 14'h2038};
    ed[0] = '{32'h0, 32'h2000_0400, 32'h0, 32'h7};
    ea[1] = '{14'h21F8, 14'h21F0, 14'h21F4, 14'h21F8};
    ed[1] = '{32'h0, 32'hC000_0001, 32'h3FFF_FFFF, 32'hA5A5_0F0F};
    for (int v = 0; v < 2; v++) begin
      reg_rsp_i = '0; reg_rsp_i.ready = 1'b1; rsp_ready_i = 1'b0;
      log_addr.delete(); log_data.delete();
      n_checks++;
      if (cmd_ready_o !== 1'b1) begin
        n_errors++; $display("FAIL prog_idle_ready v%0d: got %b required 1", v, cmd_ready_o);
      end
      cmd_valid_i = 1'b1; cmd_idx_i = vi[v]; cmd_addr_i = va[v]; cmd_cfg_i = vc[v];
      tick();
      cmd_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if ({reg_req_o.valid, reg_req_o.write, reg_req_o.wstrb, reg_req_o.addr, reg_req_o.wdata,
             busy_o, cmd_ready_o, rsp_valid_o} !==
            {1'b1, 1'b1, 4'hF, ea[v][k], ed[v][k], 1'b1, 1'b0, 1'b0}) begin
          n_errors++;
          $display("FAIL prog_write v%0d w%0d: got v=%b a=%h d=%h s=%h busy=%b cr=%b rv=%b required a=%h d=%h",
                   v, k, reg_req_o.valid, reg_req_o.addr, reg_req_o.wdata, reg_req_o.wstrb,
                   busy_o, cmd_ready_o, rsp_valid_o, ea[v][k], ed[v][k]);
        end
        tick();
      end
      n_checks++;
      if ({rsp_valid_o, rsp_code_o, reg_req_o.valid, busy_o} !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
        n_errors++; $display("FAIL prog_rsp v%0d: got rv=%b code=%0d valid=%b busy=%b required rv=1 code=0",
                             v, rsp_valid_o, rsp_code_o, reg_req_o.valid, busy_o);
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      n_checks++;
      if ({cmd_ready_o, busy_o, rsp_valid_o, log_addr.size() == 4} !== 4'b1001) begin
        n_errors++; $display("FAIL prog_done v%0d: got cr=%b busy=%b rv=%b writes=%0d required 1,0,0,4",
                             v, cmd_ready_o, busy_o, rsp_valid_o, log_addr.size());
      end
    end
  endtask

  task automatic test_bad_idx();
    logic [7:0] vi[2];
    int vc0;
    vi[0] = 8'd32; vi[1] = 8'd255;
    for (int v = 0; v < 2; v++) begin
      reg_rsp_i = '0; reg_rsp_i.ready = 1'b1; rsp_ready_i = 1'b0;
      vc0 = valid_cycles;
      cmd_valid_i = 1'b1; cmd_idx_i = vi[v]; cmd_addr_i = 64'h1234; cmd_cfg_i = 32'h1;
      tick();
      cmd_valid_i = 1'b0;
      n_checks++;
      if ({rsp_valid_o, rsp_code_o, reg_req_o.valid, busy_o, cmd_ready_o} !== {1'b1, 2'd3, 1'b0, 1'b1, 1'b0}) begin
        n_errors++; $display("FAIL bad_idx_rsp idx=%0d: got rv=%b code=%0d valid=%b busy=%b cr=%b required rv=1 code=3",
                             vi[v], rsp_valid_o, rsp_code_o, reg_req_o.valid, busy_o, cmd_ready_o);
      end
      tick();
      n_checks++;
      if ({rsp_valid_o, rsp_code_o} !== {1'b1, 2'd3}) begin
        n_errors++; $display("FAIL bad_idx_hold idx=%0d: got rv=%b code=%0d required rv=1 code=3", vi[v], rsp_valid_o, rsp_code_o);
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      n_checks++;
      if (valid_cycles != vc0 || cmd_ready_o !== 1'b1) begin
        n_errors++; $display("FAIL bad_idx_nowrite idx=%0d: got valid cycles=%0d cr=%b required 0 and 1",
                             vi[v], valid_cycles - vc0, cmd_ready_o);
      end
    end
  endtask

  task automatic test_bus_error();
    reg_rsp_i = '0; reg_rsp_i.ready = 1'b1; rsp_ready_i = 1'b0;
    log_addr.delete(); log_data.delete();
    cmd_valid_i = 1'b1; cmd_idx_i = 8'd5; cmd_addr_i = 64'h100; cmd_cfg_i = 32'h9;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    n_checks++;
    if ({reg_req_o.valid, reg_req_o.addr, reg_req_o.wdata} !== {1'b1, 14'h2050, 32'h40}) begin
      n_errors++; $display("FAIL buserr_addr_write: got v=%b a=%h d=%h required 1 2050 40",
                           reg_req_o.valid, reg_req_o.addr, reg_req_o.wdata);
    end
    reg_rsp_i.error = 1'b1;
    tick();
    reg_rsp_i.error = 1'b0;
    n_checks++;
    if ({rsp_valid_o, rsp_code_o, reg_req_o.valid} !== {1'b1, 2'd1, 1'b0}) begin
      n_errors++; $display("FAIL buserr_rsp: got rv=%b code=%0d valid=%b required rv=1 code=1 valid=0",
                           rsp_valid_o, rsp_code_o, reg_req_o.valid);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    n_checks++;
    if (log_addr.size() != 2 || cmd_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL buserr_count: got writes=%0d cr=%b required 2 and 1", log_addr.size(), cmd_ready_o);
    end
  endtask

  task automatic test_timeout();
    int bad;
    reg_rsp_i = '0; reg_rsp_i.ready = 1'b1; rsp_ready_i = 1'b0;
    log_addr.delete(); log_data.delete();
    cmd_valid_i = 1'b1; cmd_idx_i = 8'd1; cmd_addr_i = 64'h0000_0004_0000_0000; cmd_cfg_i = 32'h3;
    tick();
    cmd_valid_i = 1'b0;
    tick(); tick();
    reg_rsp_i.ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      if (!(reg_req_o.valid === 1'b1 && reg_req_o.addr === 14'h2014 && reg_req_o.wdata === 32'h1)) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL timeout_stall: got %0d bad stalled cycles required 0", bad);
    end
    n_checks++;
    if ({rsp_valid_o, rsp_code_o, reg_req_o.valid} !== {1'b1, 2'd2, 1'b0}) begin
      n_errors++; $display("FAIL timeout_rsp: got rv=%b code=%0d valid=%b required rv=1 code=2 valid=0",
                           rsp_valid_o, rsp_code_o, reg_req_o.valid);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    n_checks++;
    if (log_addr.size() != 2 || cmd_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL timeout_count: got writes=%0d cr=%b required 2 and 1", log_addr.size(), cmd_ready_o);
    end
  endtask

  task automatic test_late_ready();
    reg_rsp_i = '0; reg_rsp_i.ready = 1'b1; rsp_ready_i = 1'b0;
    log_addr.delete(); log_data.delete();
    cmd_valid_i = 1'b1; cmd_idx_i = 8'd1; cmd_addr_i = 64'h0000_0004_0000_0000; cmd_cfg_i = 32'h3;
    tick();
    cmd_valid_i = 1'b0;
    tick(); tick();
    reg_rsp_i.ready = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    reg_rsp_i.ready = 1'b1;
    n_checks++;
    if ({reg_req_o.valid, reg_req_o.addr} !== {1'b1, 14'h2014}) begin
      n_errors++; $display("FAIL late_ready_last: got v=%b a=%h required 1 2014", reg_req_o.valid, reg_req_o.addr);
    end
    tick();
    n_checks++;
    if ({reg_req_o.valid, reg_req_o.addr, reg_req_o.wdata, rsp_valid_o} !== {1'b1, 14'h2018, 32'h3, 1'b0}) begin
      n_errors++; $display("FAIL late_ready_cfg: got v=%b a=%h d=%h rv=%b required 1 2018 3 0",
                           reg_req_o.valid, reg_req_o.addr, reg_req_o.wdata, rsp_valid_o);
    end
    tick();
    n_checks++;
    if ({rsp_valid_o, rsp_code_o, log_addr.size() == 4} !== {1'b1, 2'd0, 1'b1}) begin
      n_errors++; $display("FAIL late_ready_rsp: got rv=%b code=%0d writes=%0d required 1 0 4",
                           rsp_valid_o, rsp_code_o, log_addr.size());
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc, bad_stable, bad_rdy, bad_hold, stall_run;
    logic prev_stall, r;
    logic [49:0] prev_fields;
    logic [13:0] ea[4];
    logic [31:0] ed[4];
    ea = '{14'h2078, 14'h2070, 14'h2074, 14'h2078};
    ed = '{32'h0, 32'h26AF_37BC, 32'h048D_159E, 32'h0000_0001};
    reg_rsp_i = '0; rsp_ready_i = 1'b0;
    log_addr.delete(); log_data.delete();
    cmd_valid_i = 1'b1; cmd_idx_i = 8'd7; cmd_addr_i = 64'h1234_5678_9ABC_DEF0; cmd_cfg_i = 32'h1;
    tick();
    // A second command stays pending; it must not be taken while busy.
    cmd_idx_i = 8'd9; cmd_addr_i = 64'hFFFF; cmd_cfg_i = 32'hEE;
    cyc = 0; bad_stable = 0; bad_rdy = 0; bad_hold = 0; stall_run = 0;
    prev_stall = 1'b0; prev_fields = '0;
    while (!rsp_valid_o && cyc < 200) begin
      if (cmd_ready_o !== 1'b0) bad_rdy++;
      if (prev_stall && (reg_req_o.valid !== 1'b1 ||
          {reg_req_o.addr, reg_req_o.wdata, reg_req_o.wstrb} !== prev_fields)) bad_stable++;
      r = ($urandom_range(0, 1) == 1) || (stall_run >= 6);
      stall_run = r ? 0 : stall_run + 1;
      prev_stall = reg_req_o.valid && !r;
      prev_fields = {reg_req_o.addr, reg_req_o.wdata, reg_req_o.wstrb};
      reg_rsp_i.ready = r;
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) begin
      n_errors++; $display("FAIL bp_bound: got no response after %0d cycles required response", cyc);
    end
    n_checks++;
    if (bad_stable != 0 || bad_rdy != 0) begin
      n_errors++; $display("FAIL bp_stable: got unstable=%0d cmd_ready_high=%0d required 0 0", bad_stable, bad_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      if ({rsp_valid_o, rsp_code_o, cmd_ready_o} !== {1'b1, 2'd0, 1'b0}) bad_hold++;
      tick();
    end
    n_checks++;
    if (bad_hold != 0) begin
      n_errors++; $display("FAIL bp_rsp_hold: got %0d bad held cycles required 0", bad_hold);
    end
    n_checks++;
    if (log_addr.size() != 4) begin
      n_errors++; $display("FAIL bp_count: got writes=%0d required 4", log_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if ({log_addr[k], log_data[k]} !== {ea[k], ed[k]}) begin
          n_errors++; $display("FAIL bp_write w%0d: got a=%h d=%h required a=%h d=%h",
                               k, log_addr[k], log_data[k], ea[k], ed[k]);
        end
      end
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    n_checks++;
    if ({cmd_ready_o, busy_o, rsp_valid_o} !== 3'b100) begin
      n_errors++; $display("FAIL bp_idle: got cr=%b busy=%b rv=%b required 1 0 0", cmd_ready_o, busy_o, rsp_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    reg_rsp_i = '0; reg_rsp_i.ready = 1'b1; rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_idx_i = 8'd2; cmd_addr_i = 64'h10; cmd_cfg_i = 32'h3;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    n_checks++;
    if ({reg_req_o.valid, reg_req_o.addr} !== {1'b1, 14'h2020}) begin
      n_errors++; $display("FAIL rstmid_addr: got v=%b a=%h required 1 2020", reg_req_o.valid, reg_req_o.addr);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++;
    if ({reg_req_o.valid, cmd_ready_o, busy_o, rsp_valid_o, rsp_code_o} !== 6'b010000) begin
      n_errors++; $display("FAIL rstmid_idle: got v=%b cr=%b busy=%b rv=%b code=%0d required 0 1 0 0 0",
                           reg_req_o.valid, cmd_ready_o, busy_o, rsp_valid_o, rsp_code_o);
    end
    cmd_valid_i = 1'b1; cmd_idx_i = 8'd4; cmd_addr_i = 64'h40; cmd_cfg_i = 32'h5;
    tick();
    cmd_valid_i = 1'b0;
    n_checks++;
    if ({reg_req_o.valid, reg_req_o.addr, reg_req_o.wdata} !== {1'b1, 14'h2048, 32'h0}) begin
      n_errors++; $display("FAIL rstmid_dis: got v=%b a=%h d=%h required 1 2048 0",
                           reg_req_o.valid, reg_req_o.addr, reg_req_o.wdata);
    end
    tick(); tick(); tick(); tick();
    n_checks++;
    if ({rsp_valid_o, rsp_code_o} !== {1'b1, 2'd0}) begin
      n_errors++; $display("FAIL rstmid_rsp: got rv=%b code=%0d required rv=1 code=0", rsp_valid_o, rsp_code_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_bad_idx();
    test_bus_error();
    test_timeout();
    test_late_ready();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
